// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
// Holds the screen geometry, shadow-frame address width, background colour,
// the readback FSM state type and the pixel address helper.
package snake_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;

    localparam logic [ADDR_W-1:0]   MAX_ADDR  = 15'd19199;
    localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // y*160 + x without a multiplier: 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px,
                                                     input logic [6:0] py);
        logic [ADDR_W-1:0] yw;
        yw = {8'd0, py};
        return (yw << 7) + (yw << 5) + {7'd0, px};
    endfunction

endpackage

// File: rtl/shadow_ram.sv
// Simple dual-port shadow frame memory.
// Ports:
//   clock        system clock
//   we/waddr/wdata  synchronous write port
//   re/raddr/rdata  synchronous read port; rdata holds when re is low
// A read and write to the same address on the same edge returns the old
// contents, which matches the block-RAM read-before-write behaviour.
module shadow_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_readback.sv
// Shadow framebuffer beside the VGA plot bus.
// Captures every in-range plot into a 160x120x3 memory, serves colour
// readback through a req/ready/valid handshake and sweeps the frame back to
// the background colour on request.
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   x, y, colour, plot       plot bus (one pixel per cycle)
//   plot_dropped             pulse: previous-cycle plot was discarded
//   clear_req, clear_busy    full-frame clear request / sweep in progress
//   rd_req, rd_x, rd_y       read request and coordinate
//   rd_ready                 request accepted when rd_req && rd_ready
//   rd_valid                 pulse: rd_colour / rd_oob are valid
//   rd_colour, rd_oob        read result; oob forces background colour
//
// state | meaning
// IDLE  | waiting; accepts a read, or starts a clear (clear wins)
// READ  | memory read issued at acceptance, capturing its output
// RESP  | result registered onto rd_colour/rd_oob with rd_valid
// CLEAR | writing background colour to one address per cycle
module pixel_readback
    import snake_pkg::*;
#(
    parameter int                  WIDTH     = SCREEN_W,
    parameter int                  HEIGHT    = SCREEN_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = snake_pkg::BG_COLOUR
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot,
    output logic                plot_dropped,
    input  logic                clear_req,
    output logic                clear_busy,
    input  logic                rd_req,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                rd_oob
);

    localparam logic [7:0] X_LIM = 8'(WIDTH);
    localparam logic [6:0] Y_LIM = 7'(HEIGHT);

    state_t              state;
    logic                clear_pending;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                rd_oob_q;
    logic [COLOUR_W-1:0] data_q;
    logic [COLOUR_W-1:0] ram_q;

    logic                plot_in_range;
    logic                rd_in_range;
    logic                rd_accept;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [COLOUR_W-1:0] ram_wdata;

    assign plot_in_range = (x < X_LIM) && (y < Y_LIM);
    assign rd_in_range   = (rd_x < X_LIM) && (rd_y < Y_LIM);

    assign rd_ready  = (state == IDLE) && !clear_req && !clear_pending;
    assign rd_accept = rd_req && rd_ready;

    // The sweep owns the write port while clearing; plots are dropped then.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = pixel_addr(x, y);
        ram_wdata = colour;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = BG_COLOUR;
        end else if (plot && plot_in_range) begin
            ram_we = 1'b1;
        end
    end

    // The memory is read on the accepting edge itself, so a plot to the same
    // pixel on that edge is not yet seen; out-of-range reads never touch it.
    shadow_ram #(
        .DEPTH (SCREEN_W * SCREEN_H),
        .AW    (ADDR_W),
        .DW    (COLOUR_W)
    ) u_shadow_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_accept && rd_in_range),
        .raddr (pixel_addr(rd_x, rd_y)),
        .rdata (ram_q)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            clear_busy    <= 1'b0;
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
            rd_oob_q      <= 1'b0;
            data_q        <= '0;
            rd_valid      <= 1'b0;
            rd_colour     <= '0;
            rd_oob        <= 1'b0;
            plot_dropped  <= 1'b0;
        end else begin
            plot_dropped <= plot && (!plot_in_range || (state == CLEAR));
            rd_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req || clear_pending) begin
                        state         <= CLEAR;
                        clear_busy    <= 1'b1;
                        clear_pending <= 1'b0;
                        clr_cnt       <= '0;
                    end else if (rd_req) begin
                        state    <= READ;
                        rd_oob_q <= !rd_in_range;
                    end
                end
                READ: begin
                    state  <= RESP;
                    data_q <= ram_q;
                    if (clear_req) begin
                        clear_pending <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rd_valid  <= 1'b1;
                    rd_oob    <= rd_oob_q;
                    rd_colour <= rd_oob_q ? BG_COLOUR : data_q;
                    if (clear_req) begin
                        clear_pending <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_req is deliberately ignored here: no restart.
                    if (clr_cnt == MAX_ADDR) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 15'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readback.sv
// Self-checking bench for pixel_readback: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a transaction-level model of the shadow frame.
module tb_pixel_readback;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       plot_dropped;
    logic       clear_req;
    logic       clear_busy;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_ready;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       rd_oob;

    pixel_readback dut (
        .clock        (clock),
        .resetn       (resetn),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .plot_dropped (plot_dropped),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .rd_req       (rd_req),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_colour    (rd_colour),
        .rd_oob       (rd_oob)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-stamped view: a read accepted at edge A occupies edges A+1, A+2 and
    // answers after A+2; a clear started at edge C busies edges C..C+19199 and
    // owns the memory on edges C+1..C+19200.
    longint     ek        = 0;
    longint     acc_edge  = -10;
    longint     resp_edge = -1;
    longint     clr_start = -100000;
    bit         pending   = 1'b0;
    bit         exp_drop  = 1'b0;
    logic [2:0] resp_col  = 3'd0;
    bit         resp_oob  = 1'b0;
    logic [2:0] mmem [0:19199];

    function automatic int maddr(input int px, input int py);
        return py * 160 + px;
    endfunction

    function automatic bit read_busy(input longint k);
        return k < acc_edge + 3;
    endfunction

    function automatic bit clear_active(input longint k);
        return (k >= clr_start + 1) && (k <= clr_start + 19200);
    endfunction

    function automatic bit idle_at(input longint k);
        return !read_busy(k) && !clear_active(k);
    endfunction

    function automatic bit exp_busy(input longint k);
        return (k >= clr_start) && (k < clr_start + 19200);
    endfunction

    task automatic model_step();
        bit p_oob;
        bit r_oob;
        bit start_clr;
        start_clr = 1'b0;
        if (!resetn) begin
            acc_edge  = -10;
            resp_edge = -1;
            clr_start = -100000;
            pending   = 1'b0;
            exp_drop  = 1'b0;
            return;
        end
        p_oob    = (int'(x) >= 160) || (int'(y) >= 120);
        r_oob    = (int'(rd_x) >= 160) || (int'(rd_y) >= 120);
        exp_drop = plot && (p_oob || clear_active(ek));
        if (idle_at(ek)) begin
            if (clear_req || pending) begin
                clr_start = ek;
                pending   = 1'b0;
                start_clr = 1'b1;
            end else if (rd_req) begin
                acc_edge  = ek;
                resp_edge = ek + 2;
                resp_oob  = r_oob;
                resp_col  = r_oob ? 3'd0 : mmem[maddr(int'(rd_x), int'(rd_y))];
            end
        end else if (read_busy(ek) && clear_req) begin
            pending = 1'b1;
        end
        if (plot && !p_oob && !clear_active(ek)) begin
            mmem[maddr(int'(x), int'(y))] = colour;
        end
        if (start_clr) begin
            foreach (mmem[i]) mmem[i] = 3'd0;
        end
    endtask

    initial begin
        foreach (mmem[i]) mmem[i] = 3'd0;
        forever begin
            @(posedge clock);
            ek++;
            model_step();
        end
    end

    // One compare process: every output, every cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("rd_valid", int'(rd_valid), int'(ek == resp_edge));
                if (ek == resp_edge) begin
                    chk("rd_colour", int'(rd_colour), int'(resp_col));
                    chk("rd_oob", int'(rd_oob), int'(resp_oob));
                end
                chk("plot_dropped", int'(plot_dropped), int'(exp_drop));
                chk("clear_busy", int'(clear_busy), int'(exp_busy(ek)));
                chk("rd_ready", int'(rd_ready),
                    int'(idle_at(ek + 1) && !clear_req && !pending));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic plot_px(input int px, input int py, input int c);
        x = 8'(px); y = 7'(py); colour = 3'(c); plot = 1'b1;
        tick();
        plot = 1'b0;
    endtask

    task automatic do_read(input int px, input int py,
                           output int col, output int oob, output int lat);
        int w;
        rd_x = 8'(px); rd_y = 7'(py);
        w = 0;
        while (!rd_ready && w < 100) begin
            tick();
            w++;
        end
        col = -1; oob = -1; lat = -1;
        if (!rd_ready) begin
            chk("rd_ready_timeout", 0, 1);
            return;
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        lat = 0;
        while (!rd_valid && lat < 10) begin
            tick();
            lat++;
        end
        col = int'(rd_colour);
        oob = int'(rd_oob);
    endtask

    function automatic logic [7:0] rand_x();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(152, 163))
                                           : 8'($urandom_range(0, 9));
    endfunction

    function automatic logic [6:0] rand_y();
        return ($urandom_range(0, 3) == 0) ? 7'($urandom_range(112, 123))
                                           : 7'($urandom_range(0, 9));
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int col, oob, lat, n, ready_hi, dropped_seen, valid_seen;

        resetn = 1'b0; x = 0; y = 0; colour = 0; plot = 0;
        clear_req = 0; rd_req = 0; rd_x = 0; rd_y = 0;
        repeat (2) tick();
        resetn = 1'b1;
        cmp_en = 1'b1;

        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_colour", int'(rd_colour), 0);
        chk("reset_rd_oob", int'(rd_oob), 0);
        chk("reset_plot_dropped", int'(plot_dropped), 0);
        chk("reset_clear_busy", int'(clear_busy), 0);
        chk("reset_rd_ready", int'(rd_ready), 1);

        // Establish known memory contents with a full clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_rise", int'(clear_busy), 1);
        n = 1;
        for (int i = 0; i < 20100 && clear_busy; i++) begin
            tick();
            if (clear_busy) n++;
        end
        chk("clear_len_initial", n, 19200);

        // Plot then read two cycles later.
        plot_px(80, 30, 3'b010);
        tick();
        do_read(80, 30, col, oob, lat);
        chk("t1_latency", lat, 2);
        chk("t1_colour", col, 2);
        chk("t1_oob", oob, 0);

        // Out-of-range plots.
        plot_px(160, 5, 3'b111);
        chk("t2_drop_x", int'(plot_dropped), 1);
        tick();
        chk("t2_drop_gap", int'(plot_dropped), 0);
        plot_px(5, 120, 3'b111);
        chk("t2_drop_y", int'(plot_dropped), 1);
        tick();
        do_read(159, 5, col, oob, lat);
        chk("t2_edge_colour", col, 0);
        chk("t2_edge_oob", oob, 0);
        do_read(160, 5, col, oob, lat);
        chk("t2_oob_flag", oob, 1);
        chk("t2_oob_colour", col, 0);
        chk("t2_oob_latency", lat, 2);

        // Read accepted on the same edge as a plot to the same pixel.
        x = 10; y = 10; colour = 3'b100; plot = 1'b1;
        rd_x = 10; rd_y = 10; rd_req = 1'b1;
        tick();
        plot = 1'b0; rd_req = 1'b0;
        lat = 0;
        while (!rd_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("t4_old_data", int'(rd_colour), 0);
        do_read(10, 10, col, oob, lat);
        chk("t4_new_data", col, 4);

        // Fill corners/centre, then raise clear_req during RESP of a read.
        plot_px(0, 0, 3'b111);
        plot_px(159, 119, 3'b111);
        plot_px(80, 60, 3'b111);
        rd_x = 80; rd_y = 60; rd_req = 1'b1;
        tick();                  // accepted, now READ
        rd_req = 1'b0;
        tick();                  // now RESP
        clear_req = 1'b1;
        tick();                  // back to IDLE with pending clear
        clear_req = 1'b0;
        chk("t5_valid", int'(rd_valid), 1);
        chk("t5_colour", int'(rd_colour), 7);
        chk("t5_busy_not_yet", int'(clear_busy), 0);
        chk("t5_ready_pending", int'(rd_ready), 0);
        tick();
        chk("t5_busy_start", int'(clear_busy), 1);
        n = 1; ready_hi = 0; dropped_seen = 0;
        for (int i = 0; i < 20100 && clear_busy; i++) begin
            plot = (i == 5); x = 10; y = 10; colour = 3'b101;
            clear_req = (i == 100);
            tick();
            if (i == 5) dropped_seen = int'(plot_dropped);
            if (clear_busy) begin
                n++;
                if (rd_ready) ready_hi++;
            end
        end
        plot = 1'b0; clear_req = 1'b0;
        chk("t3_clear_len", n, 19200);
        chk("t5_ready_low", ready_hi, 0);
        chk("t5_drop_in_clear", dropped_seen, 1);
        do_read(0, 0, col, oob, lat);
        chk("t3_read_0_0", col, 0);
        do_read(159, 119, col, oob, lat);
        chk("t3_read_159_119", col, 0);
        do_read(80, 60, col, oob, lat);
        chk("t3_read_80_60", col, 0);
        do_read(10, 10, col, oob, lat);
        chk("t5_read_10_10", col, 0);

        // Randomized traffic; correctness is judged by the compare process.
        for (int i = 0; i < 3000; i++) begin
            plot   = 1'($urandom_range(0, 1));
            x      = rand_x();
            y      = rand_y();
            colour = 3'($urandom_range(0, 7));
            rd_req = ($urandom_range(0, 2) == 0);
            rd_x   = rand_x();
            rd_y   = rand_y();
            tick();
        end
        plot = 1'b0; rd_req = 1'b0;
        repeat (4) tick();

        // Reset while a read is in READ.
        rd_x = 20; rd_y = 20; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6_ready_after_reset", int'(rd_ready), 1);
        chk("t6_valid_after_reset", int'(rd_valid), 0);
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_valid) valid_seen++;
        end
        chk("t6_no_valid", valid_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
